prog_loader: RTL and testbench

//  Boot-time program loader upstream of the CPU's instruction memory. Accepts a byte stream
//  (valid/ready), frames it as header + 16-bit words + checksum, and writes each word into

---
 rtl/prog_loader.sv | 80 ++++++++
 tb/tb_prog_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: frames a boot byte stream (count, words, checksum) into instruction-memory writes
// and holds the CPU in reset until a clean load completes.
module prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        start,
   output logic [15:0] mem_waddr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERROR} state_t;
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
   state_t      state, state_nx;
   logic [15:0] count, index, cnt_rx;
   logic [7:0]  sum, sum_nx, w_hi;
   logic        acc;
   always_comb begin
      state_nx = state;
      in_ready = state inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK};
      acc      = in_valid && in_ready;
      mem_we   = state == WRITE;
      cnt_rx   = {count[15:8], in_data};
      sum_nx   = sum + in_data;
      case (state)
         HDR_HI:      if (acc) state_nx = HDR_LO;
         HDR_LO:      if (acc) state_nx = cnt_rx == 16'd0 ? CHK : {1'b0, cnt_rx} > MAX_W ? ERROR : DAT_HI;
         DAT_HI:      if (acc) state_nx = DAT_LO;
         DAT_LO:      if (acc) state_nx = WRITE;
         WRITE:       state_nx = index + 16'd1 == count ? CHK : DAT_HI;
         CHK:         if (acc) state_nx = sum_nx == 8'd0 ? DONE : ERROR;
         DONE, ERROR: if (start) state_nx = HDR_HI;
         default:     state_nx = HDR_HI;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= HDR_HI;
      else      state <= state_nx;
   // Status flags are registered from the next state so they track state without glitches.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         count     <= '0;
         index     <= '0;
         sum       <= '0;
         w_hi      <= '0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         if (acc && state == HDR_HI) count[15:8] <= in_data;
         if (acc && state == HDR_LO) begin
            count[7:0] <= in_data;
            index      <= '0;
            sum        <= '0;
         end
         if (acc && state == DAT_HI) begin
            w_hi <= in_data;
            sum  <= sum_nx;
         end
         if (acc && state == DAT_LO) begin
            sum       <= sum_nx;
            mem_wdata <= {w_hi, in_data};
            mem_waddr <= 16'(index[ADDR_W-1:0]);
         end
         if (state == WRITE) index <= index + 16'd1;
         cpu_hold  <= state_nx != DONE;
         load_done <= state_nx == DONE;
         load_err  <= state_nx == ERROR;
      end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames with hand-computed writes, checksums and status flags.
module tb_prog_loader;
   logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, cpu_hold, load_done, load_err;
   logic [15:0] mem_waddr, mem_wdata;
   int          total = 0, bad = 0, fn = 0;
   logic [7:0]  fr [0:2100];
   logic [15:0] wa [$];
   logic [15:0] wd [$];

   prog_loader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .start(start), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mem_we) begin
         wa.push_back(mem_waddr);
         wd.push_back(mem_wdata);
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wa.delete();
      wd.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data = b;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) check("ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int gaps);
      for (int i = 0; i < fn; i++) begin
         if (gaps != 0) repeat (i == 3 ? 5 : $urandom_range(0, 2)) @(negedge clk);
         send_byte(fr[i]);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic set_img3(input logic [7:0] chk);
      fr[0] = 8'h00; fr[1] = 8'h03; fr[2] = 8'h12; fr[3] = 8'h34; fr[4] = 8'hAB;
      fr[5] = 8'hCD; fr[6] = 8'h00; fr[7] = 8'h01; fr[8] = chk;
      fn = 9;
   endtask

   task automatic check_img3(input string t);
      check({t, "_nwr"}, wa.size(), 3);
      if (wa.size() == 3) begin
         check({t, "_a0"}, {wa[0], wd[0]}, 32'h0000_1234);
         check({t, "_a1"}, {wa[1], wd[1]}, 32'h0001_ABCD);
         check({t, "_a2"}, {wa[2], wd[2]}, 32'h0002_0001);
      end
   endtask

   task automatic check_flags(input string t, input logic hold, input logic done, input logic err);
      check({t, "_flags"}, {cpu_hold, load_done, load_err}, {hold, done, err});
   endtask

   initial begin
      do_reset();
      check("rst_ready", in_ready, 1);
      check_flags("rst", 1, 0, 0);
      check("rst_mem", {mem_we, mem_waddr, mem_wdata}, 0);

      // 12+34+AB+CD+00+01 = 0x1BF, so 0x41 closes the sum to zero
      set_img3(8'h41);
      send_frame(0);
      check_img3("t1");
      check_flags("t1", 0, 1, 0);
      check("t1_ready", in_ready, 0);

      do_reset();
      fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h00; fn = 3;
      send_frame(0);
      check("t2_nwr", wa.size(), 0);
      check_flags("t2", 0, 1, 0);

      do_reset();
      set_img3(8'h3B);
      send_frame(0);
      check_img3("t3");
      check_flags("t3", 1, 0, 1);

      do_reset();
      send_byte(8'h04);
      send_byte(8'h01);
      @(negedge clk);
      check_flags("t4", 1, 0, 1);
      check("t4_ready", in_ready, 0);
      check("t4_nwr", wa.size(), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_restart_ready", in_ready, 1);
      check_flags("t4_restart", 1, 0, 0);

      do_reset();
      set_img3(8'h41);
      send_frame(1);
      check_img3("t5");
      check_flags("t5", 0, 1, 0);

      do_reset();
      set_img3(8'h41);
      for (int i = 0; i < 5; i++) send_byte(fr[i]);
      check("t6_pre_nwr", wa.size(), 1);
      rst = 1'b0;
      #1;
      check_flags("t6_rst", 1, 0, 0);
      check("t6_rst_mem", {mem_we, mem_waddr, mem_wdata}, 0);
      check("t6_rst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wa.delete();
      wd.delete();
      send_frame(0);
      check_img3("t6");
      check_flags("t6", 0, 1, 0);

      // BE+EF = 0x1AD, 0x53 closes it; a start mid-header must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_flags("t7_start", 1, 0, 0);
      wa.delete();
      wd.delete();
      send_byte(8'h00);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01);
      send_byte(8'hBE);
      send_byte(8'hEF);
      send_byte(8'h53);
      repeat (2) @(negedge clk);
      check("t7_nwr", wa.size(), 1);
      if (wa.size() == 1) check("t7_a0", {wa[0], wd[0]}, 32'h0000_BEEF);
      check_flags("t7", 0, 1, 0);

      begin
         logic [7:0]  s = 8'h00;
         logic [15:0] w;
         int          errs = 0;
         do_reset();
         fr[0] = 8'h04; fr[1] = 8'h00;
         for (int i = 0; i < 1024; i++) begin
            w = 16'(i) ^ 16'hA5C3;
            fr[2 + 2*i] = w[15:8];
            fr[3 + 2*i] = w[7:0];
            s = s + w[15:8] + w[7:0];
         end
         fr[2050] = 8'h00 - s;
         fn = 2051;
         send_frame(0);
         check("tmax_nwr", wa.size(), 1024);
         if (wa.size() == 1024) begin
            for (int i = 0; i < 1024; i++)
               if (wa[i] !== 16'(i) || wd[i] !== (16'(i) ^ 16'hA5C3)) errs++;
            check("tmax_data", errs, 0);
            check("tmax_last_addr", wa[1023], 16'd1023);
         end
         check_flags("tmax", 0, 1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
